// File: rtl/fmap_ser2par_if.sv
// Handshake bundle between the feature-map source,
// the column assembler and the PE array.
interface fmap_ser2par_if #(
  parameter int DW      = 32,
  parameter int ROW_LEN = 56,
  parameter int COL_NUM = 56
);
  localparam int CW =
    (COL_NUM > 1) ? $clog2(COL_NUM) : 1;

  logic [DW-1:0]         fmap_i;
  logic                  valid;
  logic                  ready;
  logic [ROW_LEN*DW-1:0] col_o;
  logic                  col_valid;
  logic                  col_ready;
  logic                  col_last;
  logic [CW-1:0]         col_idx;

  modport master (
    output fmap_i, valid, col_ready,
    input  ready, col_o, col_valid,
    input  col_last, col_idx
  );

  modport slave (
    input  fmap_i, valid, col_ready,
    output ready, col_o, col_valid,
    output col_last, col_idx
  );
endinterface

// File: rtl/fmap_ser2par.sv
// Serial-to-parallel column assembler with two
// ping-pong column banks feeding the PE array.
module fmap_ser2par #(
  parameter int DW      = 32,
  parameter int ROW_LEN = 56,
  parameter int COL_NUM = 56
) (
  input logic           clk,
  input logic           rst,
  fmap_ser2par_if.slave bus
);
  localparam int WCW =
    (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int CW =
    (COL_NUM > 1) ? $clog2(COL_NUM) : 1;

  logic [DW-1:0]  bank_q [2][ROW_LEN];
  logic [DW-1:0]  bank_d [2][ROW_LEN];
  logic [1:0]     full_q, full_d;
  logic           wr_sel_q, wr_sel_d;
  logic           rd_sel_q, rd_sel_d;
  logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]  col_cnt_q, col_cnt_d;

  logic                  ready_w;
  logic                  cvalid_w;
  logic                  accept;
  logic                  pop;
  logic [ROW_LEN*DW-1:0] col_w;

  assign ready_w  = !full_q[wr_sel_q] && !rst;
  assign cvalid_w = full_q[rd_sel_q];
  assign accept   = bus.valid && ready_w;
  assign pop      = cvalid_w && bus.col_ready;

  // Writes target wr_sel only; a full bank is
  // never written, so the read bank stays stable.
  always_comb begin
    bank_d    = bank_q;
    full_d    = full_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    wr_cnt_d  = wr_cnt_q;
    col_cnt_d = col_cnt_q;
    if (accept) begin
      bank_d[wr_sel_q][wr_cnt_q] = bus.fmap_i;
      if (wr_cnt_q == WCW'(ROW_LEN-1)) begin
        wr_cnt_d         = '0;
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
    if (pop) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
      if (col_cnt_q == CW'(COL_NUM-1))
        col_cnt_d = '0;
      else
        col_cnt_d = col_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q    <= '{default: '0};
      full_q    <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      wr_cnt_q  <= '0;
      col_cnt_q <= '0;
    end else begin
      bank_q    <= bank_d;
      full_q    <= full_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      wr_cnt_q  <= wr_cnt_d;
      col_cnt_q <= col_cnt_d;
    end
  end

  always_comb begin
    col_w = '0;
    for (int k = 0; k < ROW_LEN; k++)
      col_w[k*DW +: DW] = bank_q[rd_sel_q][k];
  end

  assign bus.ready     = ready_w;
  assign bus.col_valid = cvalid_w;
  assign bus.col_o     = col_w;
  assign bus.col_idx   = col_cnt_q;
  assign bus.col_last  =
    cvalid_w && (col_cnt_q == CW'(COL_NUM-1));
endmodule

// File: tb/tb_fmap_ser2par.sv
// Phase table plus column scoreboard for the
// serial-to-parallel column assembler.
module tb_fmap_ser2par;
  localparam int DW = 32;
  localparam int RL = 56;
  localparam int CN = 56;
  localparam int CW = $clog2(CN);

  typedef logic [RL*DW-1:0] col_t;

  typedef struct {
    bit r;
    bit v;
    bit cr;
    int n;
    bit e_ready;
    bit e_valid;
    int e_idx;
    int lane0;
    int lanel;
    int e_pops;
    int e_lasts;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  fmap_ser2par_if #(
    .DW(DW), .ROW_LEN(RL), .COL_NUM(CN)
  ) bus ();

  fmap_ser2par #(
    .DW(DW), .ROW_LEN(RL), .COL_NUM(CN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  col_t sb[$];
  col_t part;
  int   wcnt;
  int   exp_idx;
  int   next_word;
  int   pops;
  int   lasts;
  int   n_tests;
  int   n_fail;

  task automatic chk_col(input string nm);
    logic [DW-1:0] a, e;
    col_t c;
    int bad;
    n_tests++;
    c   = bus.col_o;
    bad = -1;
    for (int k = 0; k < RL; k++)
      if (bad < 0 && c[k*DW +: DW] !== sb[0][k*DW +: DW])
        bad = k;
    if (bad >= 0) begin
      n_fail++;
      a = c[bad*DW +: DW];
      e = sb[0][bad*DW +: DW];
      $display("FAIL %s t=%0t lane %0d got %0d want %0d",
               nm, $time, bad, a, e);
    end
  endtask

  task automatic step(input bit r, input bit v,
                      input bit cr);
    bit er, ev, el, pp, acc;
    rst           = r;
    bus.valid     = v;
    bus.col_ready = cr;
    bus.fmap_i    = DW'(next_word);
    @(negedge clk);
    er = !r && (sb.size() < 2);
    ev = sb.size() > 0;
    el = ev && (exp_idx == CN-1);
    pp = !r && ev && cr;
    acc = !r && v && er;
    n_tests++;
    if (bus.ready !== er || bus.col_valid !== ev ||
        bus.col_last !== el ||
        bus.col_idx !== CW'(exp_idx)) begin
      n_fail++;
      $display("FAIL cyc t=%0t rdy %b/%b vld %b/%b last %b/%b idx %0d/%0d",
               $time, bus.ready, er, bus.col_valid, ev,
               bus.col_last, el, bus.col_idx, exp_idx);
    end
    if (ev && !pp) chk_col("hold");
    if (r) begin
      sb.delete();
      part    = '0;
      wcnt    = 0;
      exp_idx = 0;
    end else begin
      if (pp) begin
        chk_col("pop");
        pops++;
        if (bus.col_last === 1'b1) lasts++;
        void'(sb.pop_front());
        exp_idx = (exp_idx + 1) % CN;
      end
      if (acc) begin
        part[wcnt*DW +: DW] = DW'(next_word);
        next_word++;
        wcnt++;
        if (wcnt == RL) begin
          sb.push_back(part);
          part = '0;
          wcnt = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_end(input string nm,
                         input vec_t t);
    logic [DW-1:0] l0, ll;
    l0 = bus.col_o[DW-1:0];
    ll = bus.col_o[(RL-1)*DW +: DW];
    n_tests++;
    if (bus.ready !== t.e_ready ||
        bus.col_valid !== t.e_valid ||
        bus.col_idx !== CW'(t.e_idx) ||
        (t.lane0 >= 0 && l0 !== DW'(t.lane0)) ||
        (t.lanel >= 0 && ll !== DW'(t.lanel)) ||
        (t.e_pops >= 0 && pops != t.e_pops) ||
        (t.e_lasts >= 0 && lasts != t.e_lasts)) begin
      n_fail++;
      $display("FAIL %s rdy %b/%b vld %b/%b idx %0d/%0d l0 %0d/%0d ll %0d/%0d pops %0d/%0d lasts %0d/%0d",
               nm, bus.ready, t.e_ready, bus.col_valid,
               t.e_valid, bus.col_idx, t.e_idx, l0, t.lane0,
               ll, t.lanel, pops, t.e_pops, lasts, t.e_lasts);
    end
  endtask

  initial begin
    vec_t tbl[14];
    vec_t h;
    n_tests   = 0;
    n_fail    = 0;
    next_word = 1;
    wcnt      = 0;
    exp_idx   = 0;
    part      = '0;
    rst       = 1'b1;
    bus.valid     = 1'b0;
    bus.col_ready = 1'b0;
    bus.fmap_i    = '0;
    @(posedge clk);
    @(posedge clk);
    #1;

    //        r  v  cr n     rdy vld idx l0   ll   pops lasts
    tbl[0]  = '{1, 1, 0, 3,    0, 0, 0, 0,   0,   -1, -1};
    tbl[1]  = '{0, 1, 0, RL,   1, 1, 0, 1,   56,  -1, -1};
    tbl[2]  = '{0, 1, 0, RL,   0, 1, 0, 1,   56,  -1, -1};
    tbl[3]  = '{0, 1, 0, 3,    0, 1, 0, 1,   56,  -1, -1};
    tbl[4]  = '{0, 0, 1, 1,    1, 1, 1, 57,  112, 1,  0};
    tbl[5]  = '{0, 0, 1, 1,    1, 0, 2, -1,  -1,  1,  0};
    tbl[6]  = '{0, 1, 0, 30,   1, 0, 2, -1,  -1,  0,  0};
    tbl[7]  = '{1, 0, 0, 1,    0, 0, 0, 0,   0,   0,  0};
    tbl[8]  = '{0, 1, 0, RL,   1, 1, 0, 143, 198, 0,  0};
    tbl[9]  = '{0, 1, 0, RL-1, 1, 1, 0, 143, 198, 0,  0};
    tbl[10] = '{0, 1, 1, 1,    1, 1, 1, 199, 254, 1,  0};
    tbl[11] = '{0, 0, 1, 1,    1, 0, 2, -1,  -1,  1,  0};
    tbl[12] = '{1, 0, 0, 1,    0, 0, 0, 0,   0,   0,  0};
    tbl[13] = '{0, 1, 1, RL*CN+1,
                               1, 0, 0, -1,  -1,  CN, 1};

    for (int i = 0; i < 14; i++) begin
      pops  = 0;
      lasts = 0;
      for (int c = 0; c < tbl[i].n; c++)
        step(tbl[i].r, tbl[i].v, tbl[i].cr);
      chk_end($sformatf("phase%0d", i), tbl[i]);
    end

    // Partial fill, reset with col_ready high,
    // then a fresh column must start at lane 0.
    pops  = 0;
    lasts = 0;
    for (int c = 0; c < 5; c++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    h = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_end("rst_hold", h);
    h.lane0 = next_word;
    for (int c = 0; c < RL; c++) step(1'b0, 1'b1, 1'b0);
    h = '{0, 1, 0, 0, 1, 1, 0, h.lane0,
          h.lane0 + RL - 1, 0, 0};
    chk_end("refill", h);
    step(1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fmap_ser2par.md
# fmap_ser2par

Serial-to-parallel column assembler that sits directly upstream of the 8-PE convolution array. It accepts one feature-map word per handshake and packs ROW_LEN consecutive words into one full column, 56 words by default. Each column is presented to the PE array as a single wide bus. Two column banks ping-pong, so the next column fills while the array consumes the current one; the block also tags the last column of each channel.

## Interface
Parameters:
- DW, 32, word width (fixed-point, IW+FW = DW upstream)
- ROW_LEN, 56, words per column (= PE_NUM × 7 lanes)
- COL_NUM, 56, columns per channel; sets col_last / col_idx wrap

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- fmap_i  in  DW  serial feature-map word
- valid  in  1  fmap_i valid
- ready  out  1  block can accept fmap_i this cycle
- col_o  out  ROW_LEN×DW  assembled column; lane k = bits [k×DW +: DW]
- col_valid  out  1  col_o holds a complete column
- col_ready  in  1  PE array accepts col_o this cycle
- col_last  out  1  current col_o is column COL_NUM-1 of the channel
- col_idx  out  clog2(COL_NUM)  index of current col_o within the channel

## Operation
State:
- Two banks B0/B1, each ROW_LEN×DW.
- full[1:0] flags.
- wr_sel, rd_sel: 1-bit bank pointers.
- wr_cnt: 0..ROW_LEN-1.
- col_cnt: 0..COL_NUM-1.

Input side:
- ready = !full[wr_sel] && !rst.
- Accept = valid && ready. On accept, fmap_i is written to lane wr_cnt of bank wr_sel, and wr_cnt increments.
- Word order is the arrival order: the first word goes to lane 0 (LSBs).
- On the accept with wr_cnt = ROW_LEN-1:
  - wr_cnt → 0.
  - full[wr_sel] ← 1.
  - wr_sel toggles.
- valid while ready=0: the word is not taken, and the source holds it.

Output side:
- col_valid = full[rd_sel].
- col_o = bank rd_sel, driven directly from the bank registers.
- Pop = col_valid && col_ready. On pop:
  - full[rd_sel] ← 0.
  - rd_sel toggles.
  - col_cnt increments, wrapping COL_NUM-1 → 0.
- col_idx = col_cnt.
- col_last = col_valid && (col_cnt == COL_NUM-1).
- col_ready while col_valid=0: ignored, no state change.

Boundary conditions:
- Both banks full: ready=0 and input stalls. After a pop, ready is 1 in the next cycle.
- Same-cycle completion and pop: if a bank completes in the same cycle the other bank is popped, both take effect. No word is lost and there is no extra stall.
- Same-bank conflict: completion and pop of the same bank in one cycle cannot occur; the bank-full gate prevents it.
- col_o stability: col_o stays stable while col_valid=1 && col_ready=0, because writes only ever target bank wr_sel ≠ rd_sel when rd is full.
- Reset mid-operation: clears everything, including partially filled banks and col_cnt; no partial column is ever emitted.

Reset values:
- ready = 0 while rst = 1.
- col_valid = 0, col_last = 0, col_idx = 0.
- col_o = 0, with all bank registers cleared.
- wr_sel = rd_sel = 0, full = 00, wr_cnt = 0.

## Timing
- Throughput: 1 word/cycle sustained when col_ready is held high; 1 column per ROW_LEN cycles.
- Latency: last word of a column accepted at edge t → col_valid=1 and col_o valid from edge t (visible in cycle t+1). First word to col_valid is ROW_LEN cycles.
- Pop at edge t → the next full bank, if any, is presented in cycle t+1, so back-to-back columns are possible.
- ready is combinational from registered state only; there is no combinational path from valid or col_ready to ready.
- col_valid and col_last depend on registered state only.

## Test plan
- Fill one column: reset, then stream words 1..56 with col_ready=0 → col_valid=1 after the 56th accept; lane 0=1, lane 55=56; col_idx=0; col_last=0; ready=1.
- Backpressure: col_ready=0, stream 112 words → ready drops to 0 after word 112; word 113 is held. Pulse col_ready once → ready=1 next cycle; col_o shows words 57..112.
- Sustained stream: valid=1 and col_ready=1 continuously for 56×56 words → 56 pops, no ready=0 cycle after the first bank; col_last=1 exactly on pop 56; col_idx wraps to 0.
- Simultaneous: the 56th word of bank B1 arrives on the same edge B0 is popped → both complete; next cycle col_o = B1 data and ready=1.
- Reset mid-column: 30 words in, assert rst one cycle, then stream 56 new words → the first column contains only the new words; col_idx=0.
- Reset outputs: hold rst high → ready=0, col_valid=0, col_last=0, col_o=0.
